// File: rtl/uart_tx_if.sv
// UART transmitter request/line bundle.
// The master drives the word and frame configuration; the slave (the core) drives the line and status.
interface uart_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output Busy
    );

endinterface

// File: rtl/uart_tx_core.sv
// UART frame serializer: one bit per clock cycle.
// A frame is a start bit, DATA_WIDTH data bits (LSB first), an optional parity bit, and a stop bit.
// The start bit appears on the same edge that accepts the request.
// A new request is taken while idle or during the stop bit, so frames can run back to back.
// Optional parity support is built in when the macro UART_TX_PARITY_EN is defined.
// Without it, PAR_EN and PAR_TYP are ignored.
module uart_tx_core #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic      CLK,
    input  logic      RST,
    uart_tx_if.slave  tx_if
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [CNT_W-1:0]      bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  tx_out_q;
    logic                  tx_out_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  accept_c;

`ifdef UART_TX_PARITY_EN
    logic                  par_en_q;
    logic                  par_en_d;
    logic                  par_typ_q;
    logic                  par_typ_d;
    logic                  parity_bit_c;
`else
    logic                  unused_cfg;

    // Parity configuration has no effect in this build.
    assign unused_cfg = tx_if.PAR_EN ^ tx_if.PAR_TYP;
`endif

    // A request is only honoured when the line is idle or on its last (stop) bit.
    assign accept_c = tx_if.DATA_VALID && ((state_q == ST_IDLE) || (state_q == ST_STOP));

    // State register plus latched word/config and the registered line outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            data_q    <= '0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
`endif
        end
    end

    // Next-state, bit counter and capture of the word on acceptance.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
`endif

        if (accept_c) begin
            data_d    = tx_if.P_DATA;
`ifdef UART_TX_PARITY_EN
            par_en_d  = tx_if.PAR_EN;
            par_typ_d = tx_if.PAR_TYP;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (accept_c) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                bit_cnt_d = '0;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    state_d   = par_en_q ? ST_PARITY : ST_STOP;
`else
                    state_d   = ST_STOP;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                bit_cnt_d = '0;
                state_d   = ST_STOP;
            end
`endif
            ST_STOP: begin
                bit_cnt_d = '0;
                state_d   = accept_c ? ST_START : ST_IDLE;
            end
            default: begin
                bit_cnt_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

`ifdef UART_TX_PARITY_EN
    // Even parity is the XOR of the data bits; odd parity inverts it.
    assign parity_bit_c = (^data_d) ^ par_typ_d;
`endif

    // Line level and Busy for the state being entered, so they register on the same edge.
    always_comb begin
        tx_out_d = 1'b1;
        busy_d   = 1'b1;
        case (state_d)
            ST_IDLE: begin
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
            end
            ST_START: begin
                tx_out_d = 1'b0;
            end
            ST_DATA: begin
                tx_out_d = data_d[bit_cnt_d];
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_out_d = parity_bit_c;
            end
`endif
            ST_STOP: begin
                tx_out_d = 1'b1;
            end
            default: begin
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign tx_if.TX_OUT = tx_out_q;
    assign tx_if.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Testbench for uart_tx_core.
// The reference model expands each accepted request into its list of line bits and replays them one per cycle.
// The expected values follow the UART_TX_PARITY_EN build the design is compiled with.
module tb_uart_tx_core;

    localparam int unsigned DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;

    uart_tx_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_core #(.DATA_WIDTH(DW)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .tx_if (bus)
    );

    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;

    bit exp_q[$];
    bit exp_tx   = 1'b1;
    bit exp_busy = 1'b0;

    // Every comparison goes through here.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expand one accepted request into its full list of line bits.
    function automatic void push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
        exp_q.push_back(1'b0);
        for (int i = 0; i < int'(DW); i++) exp_q.push_back(d[i]);
        if (HAS_PAR && pe) exp_q.push_back((^d) ^ pt);
        exp_q.push_back(1'b1);
    endfunction

    // Model the effect of one rising edge.
    // A request is taken only when no bits of the current frame remain after the one on the line.
    function automatic void model_edge();
        if (RST) begin
            exp_q.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            return;
        end
        if (exp_q.size() == 0 && bus.DATA_VALID)
            push_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
        if (exp_q.size() > 0) begin
            exp_tx   = exp_q.pop_front();
            exp_busy = 1'b1;
        end else begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end
    endfunction

    // Advance one cycle and check the line.
    // Inputs change only on the falling edge.
    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        check("tx_out", 32'(bus.TX_OUT), 32'(exp_tx));
        check("busy", 32'(bus.Busy), 32'(exp_busy));
        @(negedge CLK);
    endtask

    // Raise DATA_VALID for one cycle.
    // The inputs are then scrambled so that latching is also exercised.
    task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.DATA_VALID = 1'b1;
        tick();
        bus.DATA_VALID = 1'b0;
        bus.P_DATA     = DW'($urandom);
        bus.PAR_EN     = 1'($urandom);
        bus.PAR_TYP    = 1'($urandom);
    endtask

    // Send one frame, then count its Busy cycles.
    // The count includes the cycle in which the request is taken.
    task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt, input string tag);
        int len;
        int guard;
        send(d, pe, pt);
        len   = 1;
        guard = 0;
        while (bus.Busy && guard < 40) begin
            tick();
            if (bus.Busy) len++;
            guard++;
        end
        check({tag, "_len"}, 32'(len), 32'(DW + 2 + ((HAS_PAR && pe) ? 1 : 0)));
    endtask

    task automatic reset_pulse(input int cycles);
        RST = 1'b1;
        #1;
        exp_q.delete();
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
        check("rst_tx", 32'(bus.TX_OUT), 32'd1);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        @(negedge CLK);
        for (int i = 0; i < cycles; i++) tick();
        RST = 1'b0;
    endtask

    initial begin
        logic [9:0] cap;
        logic [DW-1:0] b2b_data [5];
        int cycles;
        int guard;

        RST            = 1'b1;
        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        #1;
        check("reset_tx", 32'(bus.TX_OUT), 32'd1);
        check("reset_busy", 32'(bus.Busy), 32'd0);
        @(negedge CLK);
        tick();
        RST = 1'b0;
        tick();
        tick();

        // The 0x2B frame without parity, checked against its literal line sequence.
        bus.P_DATA     = 8'h2B;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.DATA_VALID = 1'b1;
        cap = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cap[i] = bus.TX_OUT;
            bus.DATA_VALID = 1'b0;
        end
        check("seq_2b", 32'(cap), 32'h256);
        tick();
        check("seq_2b_idle", 32'(bus.Busy), 32'd0);

        // Frames with parity enabled (only the parity build appends the extra bit).
        run_frame(8'h2A, 1'b1, 1'b0, "even_2a");
        tick();
        run_frame(8'h2B, 1'b1, 1'b1, "odd_2b");
        tick();

        // Five frames back to back, each requested during its predecessor's stop bit.
        b2b_data = '{8'h2A, 8'hB9, 8'h24, 8'hF1, 8'h32};
        cycles = 0;
        for (int k = 0; k < 5; k++) begin
            bus.P_DATA     = b2b_data[k];
            bus.PAR_EN     = 1'b1;
            bus.PAR_TYP    = 1'b0;
            bus.DATA_VALID = 1'b1;
            tick();
            cycles++;
            bus.DATA_VALID = 1'b0;
            guard = 0;
            while (exp_q.size() > 0 && guard < 40) begin
                tick();
                cycles++;
                guard++;
            end
        end
        check("b2b_len", 32'(cycles), 32'(5 * (DW + 2 + (HAS_PAR ? 1 : 0))));
        tick();
        check("b2b_idle", 32'(bus.Busy), 32'd0);

        // A 0xFF request raised during data bit 3 of a 0x00 frame is ignored.
        send(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        bus.P_DATA     = 8'hFF;
        bus.DATA_VALID = 1'b1;
        tick();
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("ignore_idle", 32'(bus.Busy), 32'd0);

        // Reset asserted during data bit 4 aborts the frame.
        send(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        reset_pulse(2);
        for (int i = 0; i < 4; i++) tick();
        run_frame(8'hA5, 1'b1, 1'b1, "post_rst");
        tick();

        // Randomized requests, with configuration changes mid-frame and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            bus.DATA_VALID = ($urandom_range(0, 3) == 0);
            bus.P_DATA     = DW'($urandom);
            bus.PAR_EN     = 1'($urandom);
            bus.PAR_TYP    = 1'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                bus.DATA_VALID = 1'b0;
                reset_pulse(1);
            end else begin
                tick();
            end
        end
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("final_idle", 32'(bus.Busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
